// File: rtl/dec_dispatch_ctrl.sv
// dec_dispatch_ctrl: sequences master words into the caesar/scytale/zigzag demux.
// Ports:
//   clk_sys, rst_n           clock, asynchronous active-low reset
//   data_i, valid_i, sel_i   master word, valid, engine select (used on first word only)
//   ready_o                  controller can take data_i this cycle
//   busy_i                   per-engine busy flags
//   data_o, valid_o          word to the demux, held for one BYTES-cycle unpack window
//   select_o, active_o       demux select and one-hot owning engine
//   done_o, err_o            message-complete and illegal-select/timeout pulses
module dec_dispatch_ctrl #(
  parameter int                    MST_DWIDTH = 32,
  parameter int                    SYS_DWIDTH = 8,
  parameter logic [SYS_DWIDTH-1:0] END_TOKEN  = 8'hFA,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [1:0]            sel_i,
  output logic                  ready_o,
  input  logic [2:0]            busy_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [1:0]            select_o,
  output logic [2:0]            active_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int BYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW    = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int TW    = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_ENG, SEND, FETCH, DROP} state_t;

  state_t                  state, state_n;
  logic [MST_DWIDTH-1:0]   buf_q;
  logic [1:0]              sel_q;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tmo;
  logic                    done_n, err_n, xfer, eot_in, eot_buf;
  logic [3:0]              busy_ext;

  function automatic logic has_eot(input logic [MST_DWIDTH-1:0] w);
    has_eot = 1'b0;
    for (int i = 0; i < BYTES; i++) has_eot |= w[i*SYS_DWIDTH +: SYS_DWIDTH] == END_TOKEN;
  endfunction

  assign ready_o  = rst_n && (state == IDLE || state == FETCH || state == DROP);
  assign xfer     = valid_i && ready_o;
  assign eot_in   = has_eot(data_i);
  assign eot_buf  = has_eot(buf_q);
  // select 3 never reaches WAIT_ENG; the padding bit keeps the index in range
  assign busy_ext = {1'b0, busy_i};
  assign valid_o  = state == SEND;
  assign data_o   = valid_o ? buf_q : '0;
  assign select_o = sel_q;
  assign active_o = (state == WAIT_ENG || state == SEND || state == FETCH) ? 3'b001 << sel_q : 3'b000;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        state_n = sel_i == 2'd3 ? (eot_in ? IDLE : DROP) : WAIT_ENG;
        err_n   = sel_i == 2'd3;
      end
      WAIT_ENG: if (!busy_ext[sel_q]) state_n = SEND;
      SEND: if (cnt == CW'(BYTES - 1)) begin
        state_n = eot_buf ? IDLE : FETCH;
        done_n  = eot_buf;
      end
      FETCH: if (xfer) state_n = SEND;
        else if (tmo == TW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      DROP: if (xfer && eot_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      sel_q  <= '0;
      cnt    <= '0;
      tmo    <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= done_n;
      err_o  <= err_n;
      if (xfer) buf_q <= data_i;
      if (xfer && state == IDLE) sel_q <= sel_i;
      cnt <= state == SEND ? cnt + 1'b1 : '0;
      // tmo counts idle FETCH cycles; a transfer leaves FETCH so it needs no explicit clear
      tmo <= state == FETCH ? tmo + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_dec_dispatch_ctrl.sv
// tb_dec_dispatch_ctrl: directed and randomized checks of dec_dispatch_ctrl against a message-level model.
module tb_dec_dispatch_ctrl;
  localparam int TMO = 16;

  logic        clk_sys = 1'b0, rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic [1:0]  sel_i = '0;
  logic [2:0]  busy_set = '0, busy_rnd = '0, busy_i;
  logic        rnd_busy = 1'b0;
  logic        ready_o, valid_o, done_o, err_o;
  logic [31:0] data_o;
  logic [1:0]  select_o;
  logic [2:0]  active_o;

  int errors = 0, checks = 0;

  assign busy_i = rnd_busy ? busy_rnd : busy_set;

  dec_dispatch_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
    .ready_o(ready_o), .busy_i(busy_i), .data_o(data_o), .valid_o(valid_o),
    .select_o(select_o), .active_o(active_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    #2;
    busy_rnd = 3'($urandom_range(0, 7));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tok(input logic [31:0] w);
    for (int b = 0; b < 4; b++) if (((w >> (8 * b)) & 32'hFF) == 32'hFA) return 1'b1;
    return 1'b0;
  endfunction

  // Message-level model: a message owns an engine from its first legal word until
  // its token word has been sent, it times out, or reset; illegal messages are swallowed.
  int          m_left = 0, m_idle = 0;
  bit          m_wait = 0, m_drop = 0, m_msg = 0, m_last = 0, m_done = 0, m_err = 0, m_x = 0;
  logic [31:0] m_word = '0;
  logic [1:0]  m_sel = '0;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_idle = 0; m_wait = 0; m_drop = 0; m_msg = 0;
      m_last = 0; m_done = 0; m_err = 0; m_word = '0; m_sel = '0;
    end else begin
      m_x = valid_i && !m_wait && m_left == 0;
      m_done = 0;
      m_err = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_last) begin m_msg = 0; m_done = 1; end
          else m_idle = 0;
        end
      end else if (m_wait) begin
        if (!busy_i[m_sel]) begin m_wait = 0; m_left = 4; end
      end else if (m_drop) begin
        if (m_x && tok(data_i)) m_drop = 0;
      end else if (m_msg) begin
        if (m_x) begin m_word = data_i; m_last = tok(data_i); m_left = 4; end
        else begin
          m_idle++;
          if (m_idle == TMO) begin m_msg = 0; m_err = 1; end
        end
      end else if (m_x) begin
        m_sel = sel_i;
        if (sel_i == 2'd3) begin m_err = 1; m_drop = !tok(data_i); end
        else begin m_msg = 1; m_wait = 1; m_word = data_i; m_last = tok(data_i); end
      end
    end
  end

  always @(negedge clk_sys) begin
    chk("ready", {31'd0, ready_o}, {31'd0, rst_n && !m_wait && m_left == 0});
    chk("valid", {31'd0, valid_o}, {31'd0, m_left > 0});
    chk("data", data_o, m_left > 0 ? m_word : 32'd0);
    chk("select", {30'd0, select_o}, {30'd0, m_sel});
    chk("active", {29'd0, active_o}, {29'd0, m_msg ? 3'b001 << m_sel : 3'b000});
    chk("done", {31'd0, done_o}, {31'd0, m_done});
    chk("err", {31'd0, err_o}, {31'd0, m_err});
  end

  int          n_valid = 0, n_done = 0, n_err = 0;
  logic [31:0] last_data = '0;
  logic [1:0]  last_sel = '0;
  logic [2:0]  last_act = '0;

  always @(negedge clk_sys) begin
    if (valid_o) begin n_valid++; last_data = data_o; last_sel = select_o; last_act = active_o; end
    if (done_o) n_done++;
    if (err_o) n_err++;
  end

  task automatic send(input logic [31:0] d, input logic [1:0] s);
    bit r;
    int n;
    data_i = d; sel_i = s; valid_i = 1'b1;
    for (n = 0; n < 300; n++) begin
      r = ready_o;
      @(posedge clk_sys);
      #2;
      if (r) break;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
    valid_i = 1'b0; data_i = $urandom; sel_i = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #2; end
  endtask

  function automatic logic [31:0] rnd_word(input bit with_tok);
    logic [31:0] w;
    w = $urandom;
    for (int b = 0; b < 4; b++) if (w[8*b +: 8] == 8'hFA) w[8*b +: 8] = 8'h00;
    if (with_tok) w[8*$urandom_range(0, 3) +: 8] = 8'hFA;
    return w;
  endfunction

  int v0, d0, e0, nw, g;
  logic [1:0] s;

  initial begin
    idle(2);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_active", {29'd0, active_o}, 32'd0);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("idle_ready", {31'd0, ready_o}, 32'd1);
    idle(1);

    v0 = n_valid; d0 = n_done;
    send(32'h414243FA, 2'd1);
    idle(7);
    chk("single_valid_cycles", n_valid - v0, 4);
    chk("single_done", n_done - d0, 1);
    chk("single_data", last_data, 32'h414243FA);
    chk("single_sel", {30'd0, last_sel}, 32'd1);
    chk("single_act", {29'd0, last_act}, 32'b010);
    chk("single_ready", {31'd0, ready_o}, 32'd1);

    busy_set = 3'b100;
    v0 = n_valid;
    send(32'h55FA5555, 2'd2);
    idle(10);
    chk("stall_novalid", n_valid - v0, 0);
    busy_set = 3'b000;
    @(posedge clk_sys); @(negedge clk_sys);
    chk("stall_release", {31'd0, valid_o}, 32'd1);
    idle(6);
    busy_set = 3'b011;
    send(32'hFA000001, 2'd2);
    @(posedge clk_sys); @(negedge clk_sys);
    chk("other_busy_ignored", {31'd0, valid_o}, 32'd1);
    idle(6);
    busy_set = 3'b000;

    v0 = n_valid; d0 = n_done;
    send(32'h61626364, 2'd0);
    send(32'hFA000000, 2'd2);
    idle(8);
    chk("multi_valid_cycles", n_valid - v0, 8);
    chk("multi_done", n_done - d0, 1);
    chk("multi_sel", {30'd0, last_sel}, 32'd0);

    v0 = n_valid; e0 = n_err;
    send(32'h11111111, 2'd3);
    send(32'h22FA2222, 2'd3);
    @(negedge clk_sys);
    chk("illegal_ready", {31'd0, ready_o}, 32'd1);
    idle(3);
    chk("illegal_err", n_err - e0, 1);
    chk("illegal_novalid", n_valid - v0, 0);

    d0 = n_done; e0 = n_err;
    send(32'h01020304, 2'd1);
    idle(5 + TMO - 1);
    chk("timeout_early", n_err - e0, 0);
    idle(3);
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_nodone", n_done - d0, 0);
    chk("timeout_ready", {31'd0, ready_o}, 32'd1);

    d0 = n_done;
    send(32'hFA334455, 2'd2);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("pre_reset_valid", {31'd0, valid_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, valid_o}, 32'd0);
    chk("async_active", {29'd0, active_o}, 32'd0);
    chk("async_select", {30'd0, select_o}, 32'd0);
    @(posedge clk_sys); #2;
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("post_reset_ready", {31'd0, ready_o}, 32'd1);
    idle(6);
    chk("post_reset_nodone", n_done - d0, 0);

    rnd_busy = 1'b1;
    for (int m = 0; m < 250; m++) begin
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) begin
        send(rnd_word(k == nw - 1), s);
        g = ($urandom_range(0, 15) == 0) ? 24 : $urandom_range(0, 4);
        idle(g);
      end
    end
    rnd_busy = 1'b0;
    idle(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
